// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field widths and the
// fetch FSM state type.
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int FLD_W = 9;

  localparam logic [OPC_W-1:0] OP_LOAD = 5'b10011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_VALID,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Splits a 32-bit instruction word into its opcode and three operand fields.
// Purely combinational; also used by the decoder.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [31:0]      i_word,
  output logic [OPC_W-1:0] o_opcode,
  output logic [FLD_W-1:0] o_field_a,
  output logic [FLD_W-1:0] o_field_b,
  output logic [FLD_W-1:0] o_field_c
);

  assign o_opcode  = i_word[31:27];
  assign o_field_a = i_word[26:18];
  assign o_field_b = i_word[17:9];
  assign o_field_c = i_word[8:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address, captures the
// registered read word and presents it to the decoder over valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int  data_length = 32,
  parameter int  mem_length  = 64,
  parameter int  RESET_PC    = 0,
  localparam int AW          = $clog2(mem_length)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [AW-1:0]          imem_addr,
  input  logic [data_length-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [data_length-1:0] instr,
  output logic [OPC_W-1:0]       opcode,
  output logic [FLD_W-1:0]       field_a,
  output logic [FLD_W-1:0]       field_b,
  output logic [FLD_W-1:0]       field_c,
  output logic [AW-1:0]          pc,
  output logic                   halted,
  output fetch_state_t           dbg_state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(mem_length - 1);
  localparam logic [AW-1:0] START_PC  = AW'(RESET_PC);

  fetch_state_t           r_state;
  fetch_state_t           w_next_state;
  logic [AW-1:0]          r_fetch_pc;
  logic [AW-1:0]          r_pc;
  logic [data_length-1:0] r_ir;
  logic                   w_word_halt;
  logic                   w_capture;
  logic [AW-1:0]          w_pc_inc;
  logic                   w_instr_valid;
  logic                   w_halted;

  assign w_word_halt = (imem_rdata[31:27] == OP_HALT);
  // A redirect in CAPTURE wins: the word read for the old stream is dropped.
  assign w_capture   = (r_state == ST_CAPTURE) && !w_word_halt && !redirect;
  assign w_pc_inc    = (r_fetch_pc == LAST_ADDR) ? '0 : r_fetch_pc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect) begin
      w_next_state = en ? ST_ISSUE : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (en) w_next_state = ST_ISSUE;
        ST_ISSUE:   w_next_state = ST_CAPTURE;
        ST_CAPTURE: w_next_state = w_word_halt ? ST_HALT : ST_VALID;
        ST_VALID:   if (instr_ready) w_next_state = en ? ST_ISSUE : ST_IDLE;
        ST_HALT:    w_next_state = ST_HALT;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // Handshake: a word transfers on any rising edge where instr_valid and
  // instr_ready are both high; instr_valid never drops and the presented word
  // never changes until that transfer, except on redirect or reset.
  always_comb begin
    w_instr_valid = (r_state == ST_VALID);
    w_halted      = (r_state == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= START_PC;
      r_ir       <= '0;
      r_pc       <= '0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= redirect_addr;
      end else if (w_capture) begin
        r_fetch_pc <= w_pc_inc;
      end
      if (w_capture) begin
        r_ir <= imem_rdata;
        r_pc <= r_fetch_pc;
      end
    end
  end

  instr_field_split u_split (
    .i_word    (r_ir[31:0]),
    .o_opcode  (opcode),
    .o_field_a (field_a),
    .o_field_b (field_b),
    .o_field_c (field_c)
  );

  assign imem_addr   = r_fetch_pc;
  assign instr       = r_ir;
  assign pc          = r_pc;
  assign instr_valid = w_instr_valid;
  assign halted      = w_halted;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered instruction memory, transaction-level
// reference model, directed scenarios and a randomized run.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DL = 32;
  localparam int ML = 64;
  localparam int AW = 6;

  logic          clk = 0;
  logic          rst;
  logic          en;
  logic [AW-1:0] imem_addr;
  logic [DL-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DL-1:0] instr;
  logic [4:0]    opcode;
  logic [8:0]    field_a, field_b, field_c;
  logic [AW-1:0] pc;
  logic          halted;
  fetch_state_t  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [ML];

  fetch_unit #(.data_length(DL), .mem_length(ML), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .field_a(field_a),
    .field_b(field_b), .field_c(field_c), .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) imem_rdata <= '0;
    else     imem_rdata <= mem[imem_addr];
  end

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 fetching (edges left in m_wait), 2 presenting, 3 halted.
  int          m_mode;
  int          m_wait;
  int          m_addr;
  logic [31:0] m_last_instr;
  int          m_last_pc;

  function automatic int wrap_next(input int a);
    return (a + 1) % ML;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_wait <= 0; m_addr <= 0; m_last_instr <= 0; m_last_pc <= 0;
    end else if (redirect) begin
      m_addr <= int'(redirect_addr);
      m_mode <= en ? 1 : 0;
      m_wait <= 2;
    end else begin
      case (m_mode)
        0: if (en) begin m_mode <= 1; m_wait <= 2; end
        1: begin
          if (m_wait == 1) begin
            if ((mem[m_addr] >> 27) == 0) m_mode <= 3;
            else begin
              m_mode <= 2; m_last_instr <= mem[m_addr]; m_last_pc <= m_addr;
            end
          end else m_wait <= m_wait - 1;
        end
        2: if (instr_ready) begin
          m_addr <= wrap_next(m_addr);
          m_mode <= en ? 1 : 0;
          m_wait <= 2;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int exp_addr;
    exp_addr = (m_mode == 2) ? wrap_next(m_addr) : m_addr;
    check("cmp_valid",   32'(instr_valid), (m_mode == 2) ? 32'd1 : 32'd0);
    check("cmp_halted",  32'(halted),      (m_mode == 3) ? 32'd1 : 32'd0);
    check("cmp_addr",    32'(imem_addr),   32'(exp_addr));
    check("cmp_instr",   instr,            m_last_instr);
    check("cmp_pc",      32'(pc),          32'(m_last_pc));
    check("cmp_opcode",  32'(opcode),      m_last_instr >> 27);
    check("cmp_field_a", 32'(field_a),     (m_last_instr >> 18) & 32'h1FF);
    check("cmp_field_b", 32'(field_b),     (m_last_instr >> 9) & 32'h1FF);
    check("cmp_field_c", 32'(field_c),     m_last_instr & 32'h1FF);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (instr_valid !== 1'b1 && k < 40) begin step(); k++; end
    check("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [AW-1:0] a);
    redirect = 1; redirect_addr = a;
    step();
    redirect = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [31:0] hold_instr;
    for (int i = 0; i < ML; i++) mem[i] = {5'($urandom_range(1, 31)), 27'($urandom)};
    mem[0] = 32'h98000200; mem[1] = 32'h30040601; mem[2] = 32'h98040400;
    mem[3] = 32'h30040a03; mem[4] = 32'h30000202; mem[5] = 32'h98060c05;
    mem[6] = 32'h0;        mem[40] = 32'h0;       mem[63] = 32'h3007fe3f;

    rst = 1; en = 0; instr_ready = 0; redirect = 0; redirect_addr = 0;
    repeat (3) step();
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_addr",  32'(imem_addr), 0);
    check("rst_instr", instr, 0);
    check("rst_pc",    32'(pc), 0);
    check("rst_halt",  32'(halted), 0);
    rst = 0;
    step();

    // default program with ready held high
    en = 1; instr_ready = 1;
    step(); step();
    check("latency_pre", 32'(instr_valid), 0);
    step();
    check("latency", 32'(instr_valid), 1);
    for (int p = 0; p < 6; p++) begin
      wait_valid(k);
      if (p > 0) check("throughput", 32'(k), 2);
      check("prog_pc", 32'(pc), 32'(p));
      if (p == 0) begin
        check("prog0_instr", instr, 32'h98000200);
        check("prog0_opcode", 32'(opcode), 32'b10011);
      end
      if (p == 4) begin
        check("prog4_instr", instr, 32'h30000202);
        check("prog4_field_c", 32'(field_c), 2);
      end
      step();
    end
    k = 0;
    while (halted !== 1'b1 && k < 10) begin step(); k++; end
    check("halt_set", 32'(halted), 1);
    check("halt_no_valid", 32'(instr_valid), 0);
    check("halt_addr", 32'(imem_addr), 6);

    // halt exit via redirect
    do_redirect(0);
    check("halt_clear", 32'(halted), 0);
    check("exit_addr", 32'(imem_addr), 0);
    wait_valid(k);
    check("exit_latency", 32'(k), 2);
    check("exit_pc", 32'(pc), 0);
    check("exit_instr", instr, 32'h98000200);
    step();

    // backpressure at pc 1
    wait_valid(k);
    check("bp_pc0", 32'(pc), 1);
    instr_ready = 0;
    hold_instr = instr;
    repeat (5) begin
      step();
      check("bp_valid", 32'(instr_valid), 1);
      check("bp_instr", instr, hold_instr);
      check("bp_pc", 32'(pc), 1);
      check("bp_addr", 32'(imem_addr), 2);
    end
    instr_ready = 1;
    step();

    // redirect while pc 1 is in CAPTURE
    do_redirect(0);
    wait_valid(k);
    check("rd_pc0", 32'(pc), 0);
    step();
    step();
    do_redirect(4);
    check("rd_valid", 32'(instr_valid), 0);
    check("rd_addr", 32'(imem_addr), 4);
    wait_valid(k);
    check("rd_pc4", 32'(pc), 4);
    check("rd_instr", instr, 32'h30000202);
    step();

    // wrap-around
    do_redirect(63);
    wait_valid(k);
    check("wrap_pc63", 32'(pc), 63);
    check("wrap_instr63", instr, 32'h3007fe3f);
    step();
    wait_valid(k);
    check("wrap_pc0", 32'(pc), 0);
    check("wrap_instr0", instr, 32'h98000200);
    step();

    // asynchronous reset while presenting
    wait_valid(k);
    #2 rst = 1;
    #1;
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_addr", 32'(imem_addr), 0);
    check("arst_pc", 32'(pc), 0);
    step();
    rst = 0;
    step();

    // randomized run
    for (int c = 0; c < 3000; c++) begin
      en            = ($urandom_range(0, 9) != 0);
      instr_ready   = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 24) == 0);
      redirect_addr = AW'($urandom_range(0, ML - 1));
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; redirect = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and the decode/execute logic. Drives the instruction memory address bus, captures the registered 32-bit read data, and presents the instruction with its split fields to the decoder over a valid/ready handshake. It also handles sequential PC advance with wrap-around, jump/branch redirects and halt on an all-zero word.

## Interface
- `data_length`, 32: instruction width.
- `mem_length`, 64: instruction memory depth. `AW = $clog2(mem_length)`.
- `RESET_PC`, 0: first fetch address after reset.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: run enable. Sampled in IDLE and on handshake completion.
- `imem_addr`  out  AW: to instruction memory `addr`. Memory `we` is tied low at top level.
- `imem_rdata`  in  data_length: memory read data. Valid one edge after the address is stable.
- `redirect`  in  1: single-cycle jump/branch request.
- `redirect_addr`  in  AW: jump/branch target.
- `instr_valid`  out  1: instruction outputs are valid.
- `instr_ready`  in  1: consumer accepts the instruction.
- `instr`  out  data_length: raw instruction word.
- `opcode`  out  5: `instr[31:27]`.
- `field_a`  out  9: `instr[26:18]`.
- `field_b`  out  9: `instr[17:9]`.
- `field_c`  out  9: `instr[8:0]`.
- `pc`  out  AW: address of the word held in `instr`.
- `halted`  out  1: fetch is stopped on an OP_HALT word.

## Operation
- Registers:
  - `fetch_pc`: the next address to fetch; `imem_addr = fetch_pc`.
  - `ir`, `pc`, `state`.
- FSM states: IDLE, ISSUE, CAPTURE, VALID, HALT.
  - IDLE: if `en`, go to ISSUE; otherwise stay.
  - ISSUE: `imem_addr` is held for one edge so the memory registers `instructs[fetch_pc]`. Always goes to CAPTURE.
  - CAPTURE, when `imem_rdata[31:27] == OP_HALT`: go to HALT. `instr_valid` stays 0 and `fetch_pc` is unchanged.
  - CAPTURE, otherwise: `ir <= imem_rdata`, `pc <= fetch_pc`, `fetch_pc <= (fetch_pc == mem_length-1) ? 0 : fetch_pc+1`, then go to VALID.
  - VALID: `instr_valid = 1`. On `instr_ready`, go to ISSUE if `en`, else IDLE. Without `instr_ready`, stay.
  - HALT: `halted = 1`. Leave only on reset or redirect.
- Redirect (any state, including HALT):
  - `fetch_pc <= redirect_addr`.
  - Any captured or in-flight word is discarded.
  - Next state is ISSUE if `en`, else IDLE. `halted` clears.
- Redirect together with `instr_valid & instr_ready` in the same cycle: the transfer counts as completed, then the redirect applies.
- Dropping `en` mid-fetch: ISSUE and CAPTURE run to completion. VALID holds until accepted; the FSM then goes to IDLE.
- Output fields are combinational slices of `ir`. No decode beyond splitting.

## Timing
- Reset values: state IDLE, `fetch_pc = RESET_PC`, `imem_addr = RESET_PC`, `ir = 0`, `opcode = 0`, all fields 0, `pc = 0`, `instr_valid = 0`, `halted = 0`.
- Latency: `en` sampled high in IDLE at edge N gives `instr_valid` high in the cycle after edge N+2.
- Throughput: one instruction per 3 cycles when `instr_ready` is held high.
- While `instr_valid & !instr_ready`, all of `instr`, `opcode`, `field_a`, `field_b`, `field_c` and `pc` stay stable.
- A redirect at edge N puts `redirect_addr` on `imem_addr` after edge N. `instr_valid` is 0 from then until the new word is captured.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). The memory's own synchronous `rst` returns `rdata = 0`, but no capture occurs while `rst` is high.

## Structure
- Package `cpu_pkg` holds:
  - Opcode constants: `OP_LOAD = 5'b10011`, `OP_ADD = 5'b00110`, `OP_HALT = 5'b00000`.
  - Field widths: `OPC_W = 5`, `FLD_W = 9`.
  - The FSM state enum `fetch_state_t`.
- Sub-module `instr_field_split`: combinational split of a word into `opcode` and `field_a/b/c`. It is reused by the decoder.

## Test plan
- Memory loaded with default program:
  - Stimulus: reset, then `en = 1`, `instr_ready = 1`.
  - Required: `pc = 0` with `instr = 32'h98000200` and `opcode = 5'b10011`; then `pc = 1`, 2, 3; then `pc = 4` with `instr = 32'h30000202` and `field_c = 2`; then `pc = 5`. `halted = 1` after reading address 6, and `instr_valid` is never asserted for address 6.
- Backpressure:
  - Stimulus: `instr_ready = 0` for 5 cycles at `pc = 1`.
  - Required: `instr_valid` and all outputs stable for all 5 cycles; `imem_addr` holds 2.
- Redirect:
  - Stimulus: `redirect = 1`, `redirect_addr = 4` while in CAPTURE of `pc = 1`.
  - Required: the `pc = 1` word is never presented; next presented `pc = 4`, `instr = 32'h30000202`.
- Wrap-around:
  - Stimulus: redirect to 63 with a non-zero word at 63 and at 0.
  - Required: presented `pc = 63` then `pc = 0`.
- Halt exit:
  - Stimulus: while halted, `redirect = 1`, `redirect_addr = 0`.
  - Required: `halted` falls; `pc = 0` word presented 3 cycles later.
- Async reset mid-VALID:
  - Stimulus: assert `rst` between clock edges.
  - Required: `instr_valid = 0` and `imem_addr = 0` immediately, before the next edge.
